button_conditioner: RTL and testbench

//   Input-side front end for the dice game. Takes raw active-low pushbuttons
//   (roll, game reset, ...) from the board and delivers clean, synchronised,

---
 rtl/button_conditioner_if.sv | 29 ++
 rtl/button_conditioner.sv | 157 +++++++++++++++
 tb/tb_button_conditioner.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button bundle between the board-side pushbuttons and the game FSM.
// The master side is the conditioner: it takes raw active-low buttons
// and produces clean levels and press/release strobes. The slave side is
// whoever supplies the buttons and consumes the conditioned outputs.
interface button_conditioner_if #(
  parameter int BTN_W = 2
);
  logic [BTN_W-1:0] btn_n;        // raw buttons, active-low, asynchronous, bouncy
  logic [BTN_W-1:0] btn_level;    // debounced level, 1 = pressed
  logic [BTN_W-1:0] btn_press;    // one-cycle strobe on accepted press
  logic [BTN_W-1:0] btn_release;  // one-cycle strobe on accepted release
  logic             any_press;    // OR of btn_press, same cycle

  modport master (
    input  btn_n,
    output btn_level,
    output btn_press,
    output btn_release,
    output any_press
  );

  modport slave (
    output btn_n,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  any_press
  );
endinterface

// File: rtl/button_conditioner.sv
// Input-side front end for the dice game. Each raw active-low pushbutton is
// inverted, synchronised with two flops and then debounced by a small
// per-channel FSM with a qualification counter, so that one physical press
// yields exactly one btn_press strobe and one release yields one
// btn_release strobe. Channels are fully independent.
module button_conditioner #(
  parameter int BTN_W           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  button_conditioner_if.master btn
);

  // Elaboration-time sanity check of the parameter set: the counter must be
  // able to hold DEBOUNCE_CYCLES-1 and at least one stable cycle is needed.
  if (DEBOUNCE_CYCLES < 1 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_param_check
    $error("button_conditioner: need DEBOUNCE_CYCLES >= 1 and 2**CNT_W > DEBOUNCE_CYCLES");
  end

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_e;

  // Terminal count: a change is accepted when the counter has reached this
  // value and the synchronised input still disagrees with the current level.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-stage synchroniser, carrying active-high "pressed" values.
  logic [BTN_W-1:0] sync1_q;
  logic [BTN_W-1:0] sync2_q;

  // Collected per-channel registered outputs.
  logic [BTN_W-1:0] level_vec;
  logic [BTN_W-1:0] press_vec;
  logic [BTN_W-1:0] release_vec;

  // Invert the raw buttons and bring them into the clock domain.
  // NOTE: clocked blocks use non-blocking (<=) so sync2_q samples the old
  // sync1_q; a blocking assignment here would collapse the two stages into one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~btn.btn_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < BTN_W; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             s;

    assign s = sync2_q[i];

    // Channel state, counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q   <= RELEASED;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Debounce decision: qualify a change for DEBOUNCE_CYCLES further
    // stable samples, drop back on any bounce, strobe once on acceptance.
    // NOTE: every _d is given a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;

      case (state_q)
        RELEASED: begin
          if (s) begin
            state_d = PRESS_CHK;
            cnt_d   = '0;
          end
        end

        PRESS_CHK: begin
          if (!s) begin
            state_d = RELEASED;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            press_d = 1'b1;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_CHK;
            cnt_d   = '0;
          end
        end

        RELEASE_CHK: begin
          if (s) begin
            state_d = PRESSED;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = RELEASED;
            release_d = 1'b1;
            level_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = RELEASED;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

    assign level_vec[i]   = level_q;
    assign press_vec[i]   = press_q;
    assign release_vec[i] = release_q;

    // Strobes on one channel are mutually exclusive and the counter never
    // passes its terminal value.
    a_no_overlap : assert property (@(posedge clock) disable iff (reset)
      !(press_q && release_q));
    a_cnt_bound : assert property (@(posedge clock) disable iff (reset)
      cnt_q <= CNT_LAST);
  end

  assign btn.btn_level   = level_vec;
  assign btn.btn_press   = press_vec;
  assign btn.btn_release = release_vec;
  assign btn.any_press   = |press_vec;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4.
// A cycle-level reference model (run-length of samples disagreeing with
// the accepted level, behind a two-stage delay) pushes expected outputs
// into a scoreboard queue as stimulus is driven; a monitor pops and
// compares just after every clock edge. A table of stimulus segments adds
// hand-derived end-of-segment level and strobe-count checks, and
// hand-written sequences cover asynchronous reset.
module tb_button_conditioner;

  localparam int BTN_W = 2;
  localparam int DEB   = 4;
  localparam int CNT_W = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  button_conditioner_if #(.BTN_W(BTN_W)) bif ();

  button_conditioner #(
    .BTN_W          (BTN_W),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn  (bif.master)
  );

  typedef struct packed {
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
    logic       any;
  } exp_t;

  typedef struct {
    string      name;
    logic [1:0] btn_n;
    int         cycles;
    logic [1:0] exp_level;
    int         p0, p1, r0, r1;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   press_seen[2];
  int   rel_seen[2];

  // Reference model state.
  logic [1:0] m_sd1, m_sd2, m_lvl;
  int         m_run[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sd1 = '0;
    m_sd2 = '0;
    m_lvl = '0;
    m_run[0] = 0;
    m_run[1] = 0;
  endtask

  // Expected outputs right after the edge that samples bn.
  task automatic model_step(input logic [1:0] bn, output exp_t e);
    logic [1:0] s;
    s     = m_sd2;
    m_sd2 = m_sd1;
    m_sd1 = ~bn;
    e     = '0;
    for (int ch = 0; ch < 2; ch++) begin
      if (s[ch] != m_lvl[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == DEB + 1) begin
          m_lvl[ch] = s[ch];
          m_run[ch] = 0;
          if (s[ch]) e.press[ch] = 1'b1;
          else       e.rel[ch]   = 1'b1;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
    e.level = m_lvl;
    e.any   = |e.press;
  endtask

  // Drive one cycle of stimulus for the next rising edge and queue its result.
  task automatic drive_cycle(input logic [1:0] bn);
    exp_t e;
    @(posedge clock);
    #2;
    bif.btn_n = bn;
    model_step(bn, e);
    sb_q.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_level"},   32'(bif.btn_level),   32'd0);
    check({tag, "_press"},   32'(bif.btn_press),   32'd0);
    check({tag, "_release"}, 32'(bif.btn_release), 32'd0);
    check({tag, "_any"},     32'(bif.any_press),   32'd0);
  endtask

  // Assert reset between edges and confirm outputs clear without a clock.
  task automatic async_reset(input string tag);
    @(posedge clock);
    #4;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs_zero(tag);
    repeat (2) @(posedge clock);
    #1;
    check({tag, "_held_level"}, 32'(bif.btn_level), 32'd0);
  endtask

  // Deassert reset with the buttons at bn; the following edge is modelled.
  task automatic release_reset(input logic [1:0] bn);
    exp_t e;
    @(posedge clock);
    #2;
    reset     = 1'b0;
    bif.btn_n = bn;
    model_reset();
    model_step(bn, e);
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor: compare just after each edge that has a queued expectation.
  always @(posedge clock) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("sb_level",   32'(bif.btn_level),   32'(mon_e.level));
      check("sb_press",   32'(bif.btn_press),   32'(mon_e.press));
      check("sb_release", 32'(bif.btn_release), 32'(mon_e.rel));
      check("sb_any",     32'(bif.any_press),   32'(mon_e.any));
      for (int ch = 0; ch < 2; ch++) begin
        if (bif.btn_press[ch])   press_seen[ch]++;
        if (bif.btn_release[ch]) rel_seen[ch]++;
      end
    end
  end

  initial begin
    int pb[2];
    int rb[2];

    vecs = '{
      '{"idle",       2'b11,    5, 2'b00, 0, 0, 0, 0},
      '{"t1_hold",    2'b10,   20, 2'b01, 1, 0, 0, 0},
      '{"t1_rel",     2'b11,   10, 2'b00, 0, 0, 1, 0},
      '{"t2_bnc_lo",  2'b10,    3, 2'b00, 0, 0, 0, 0},
      '{"t2_bnc_hi",  2'b11,    1, 2'b00, 0, 0, 0, 0},
      '{"t2_stable",  2'b10,   12, 2'b01, 1, 0, 0, 0},
      '{"t2_rel",     2'b11,   10, 2'b00, 0, 0, 1, 0},
      '{"t3_short",   2'b10,    2, 2'b00, 0, 0, 0, 0},
      '{"t3_idle",    2'b11,    8, 2'b00, 0, 0, 0, 0},
      '{"t4_both",    2'b00,   10, 2'b11, 1, 1, 0, 0},
      '{"t4_rel",     2'b11,   10, 2'b00, 0, 0, 1, 1},
      '{"rb_hold",    2'b10,   10, 2'b01, 1, 0, 0, 0},
      '{"rb_bounce",  2'b11,    2, 2'b01, 0, 0, 0, 0},
      '{"rb_hold2",   2'b10,   10, 2'b01, 0, 0, 0, 0},
      '{"rb_rel",     2'b11,   10, 2'b00, 0, 0, 1, 0},
      '{"t6_hold",    2'b01, 1000, 2'b10, 0, 1, 0, 0},
      '{"t6_rel",     2'b11,   10, 2'b00, 0, 0, 0, 1}
    };

    press_seen[0] = 0; press_seen[1] = 0;
    rel_seen[0]   = 0; rel_seen[1]   = 0;
    model_reset();
    bif.btn_n = 2'b11;
    reset     = 1'b1;

    // Reset state before any clock edge.
    #1;
    check_outputs_zero("por");
    #20;
    release_reset(2'b11);

    // Table-driven segments.
    for (int v = 0; v < NV; v++) begin
      pb = press_seen;
      rb = rel_seen;
      repeat (vecs[v].cycles) drive_cycle(vecs[v].btn_n);
      check({vecs[v].name, "_level"},    32'(bif.btn_level),      32'(vecs[v].exp_level));
      check({vecs[v].name, "_press0"},   32'(press_seen[0] - pb[0]), 32'(vecs[v].p0));
      check({vecs[v].name, "_press1"},   32'(press_seen[1] - pb[1]), 32'(vecs[v].p1));
      check({vecs[v].name, "_release0"}, 32'(rel_seen[0] - rb[0]),   32'(vecs[v].r0));
      check({vecs[v].name, "_release1"}, 32'(rel_seen[1] - rb[1]),   32'(vecs[v].r1));
    end

    // Reset during press qualification, button still held afterwards.
    repeat (4) drive_cycle(2'b10);
    async_reset("rst_chk");
    pb = press_seen;
    release_reset(2'b10);
    repeat (11) drive_cycle(2'b10);
    check("rst_chk_requal_press", 32'(press_seen[0] - pb[0]), 32'd1);
    check("rst_chk_requal_level", 32'(bif.btn_level), 32'd1);

    // Reset while pressed: level must drop at once, then one fresh press.
    repeat (3) drive_cycle(2'b10);
    check("rst_prs_pre_level", 32'(bif.btn_level), 32'd1);
    rb = rel_seen;
    async_reset("rst_prs");
    pb = press_seen;
    release_reset(2'b10);
    repeat (11) drive_cycle(2'b10);
    check("rst_prs_requal_press", 32'(press_seen[0] - pb[0]), 32'd1);
    check("rst_prs_no_release",   32'(rel_seen[0] - rb[0]),   32'd0);
    rb = rel_seen;
    repeat (10) drive_cycle(2'b11);
    check("rst_prs_final_release", 32'(rel_seen[0] - rb[0]), 32'd1);
    check("rst_prs_final_level",   32'(bif.btn_level), 32'd0);

    // Let the monitor consume the last queued expectation.
    @(posedge clock);
    #3;
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
